// File: rtl/gemm_sequencer_pkg.sv
// Shared types and defaults for the GEMM instruction sequencer.
package gemm_sequencer_pkg;

  localparam int INSTR_SIZE = 32;
  localparam int KT_W_DEF   = 8;
  localparam int ROW_W_DEF  = 10;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_GEMM = 2'b01,
    OP_RSV0 = 2'b10,
    OP_RSV1 = 2'b11
  } opcode_e;

  // Low 32 bits of an instruction word; rsvd is don't-care.
  typedef struct packed {
    opcode_e     opcode;
    logic        acc_en;
    logic [7:0]  k_tiles_m1;
    logic [9:0]  rows_m1;
    logic [10:0] rsvd;
  } gemm_instr_t;

endpackage

// File: rtl/gemm_sequencer_fifo.sv
// Instruction FIFO: registered count drives full/empty, so a push into an
// empty FIFO is only visible to the reader one cycle later.
module instr_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [AW:0]   cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset; the count defines what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/gemm_sequencer.sv
// Tiled GEMM instruction sequencer: pops instructions from a small FIFO and
// walks each GEMM through K-tiles of clear / weight load / switch / stream.
module gemm_sequencer
  import gemm_sequencer_pkg::*;
#(
  parameter int INSTR_W    = INSTR_SIZE,
  parameter int FIFO_DEPTH = 4,
  parameter int KT_W       = KT_W_DEF,
  parameter int ROW_W      = ROW_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               instr_valid_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               instr_ready_o,
  input  logic               start_i,
  input  logic               w_done_i,
  input  logic               o_done_i,
  output logic               w_read_o,
  output logic               if_read_o,
  output logic               clr_w_o,
  output logic               clr_if_o,
  output logic               switch_o,
  output logic               first_o,
  output logic               last_o,
  output logic               busy_o,
  output logic               instr_done_o,
  output logic               err_o,
  output logic [15:0]        done_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CLR, S_LOAD_W, S_SWITCH, S_STREAM, S_DRAIN
  } state_e;

  state_e             state_q, state_d;
  logic [KT_W-1:0]    k_cnt_q, k_cnt_d, kt_q, kt_d;
  logic [ROW_W-1:0]   row_cnt_q, row_cnt_d, rows_q, rows_d;
  logic [15:0]        done_cnt_q, done_cnt_d;
  opcode_e            op_q, op_d;
  logic               acc_q, acc_d;
  logic               pop;
  logic               fifo_full, fifo_empty;
  logic [INSTR_W-1:0] fifo_rdata;
  gemm_instr_t        hd;
  logic               unused_bits;

  // Registered Moore outputs.
  logic w_read_q, if_read_q, clr_q, switch_q, first_q, last_q, busy_q, err_q;

  instr_fifo #(.W(INSTR_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (instr_valid_i),
    .data_i  (instr_i),
    .pop_i   (pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign hd          = gemm_instr_t'(fifo_rdata[31:0]);
  assign unused_bits = ^hd.rsvd;

  // Next-state logic; fields are captured at the pop since the FIFO head
  // has already advanced by the time FETCH decodes them.
  always_comb begin
    state_d    = state_q;
    k_cnt_d    = k_cnt_q;
    row_cnt_d  = row_cnt_q;
    done_cnt_d = done_cnt_q;
    op_d       = op_q;
    acc_d      = acc_q;
    kt_d       = kt_q;
    rows_d     = rows_q;
    pop        = 1'b0;
    unique case (state_q)
      S_IDLE: if (start_i && !fifo_empty) begin
        pop     = 1'b1;
        op_d    = hd.opcode;
        acc_d   = hd.acc_en;
        kt_d    = KT_W'(hd.k_tiles_m1);
        rows_d  = ROW_W'(hd.rows_m1);
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (op_q == OP_GEMM) begin
          k_cnt_d = '0;
          state_d = S_CLR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLR:    state_d = S_LOAD_W;
      S_LOAD_W: if (w_done_i) state_d = S_SWITCH;
      S_SWITCH: begin
        row_cnt_d = '0;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        if (row_cnt_q == rows_q) begin
          if (k_cnt_q == kt_q) begin
            state_d = S_DRAIN;
          end else begin
            k_cnt_d = k_cnt_q + 1'b1;
            state_d = S_CLR;
          end
        end else begin
          row_cnt_d = row_cnt_q + 1'b1;
        end
      end
      S_DRAIN: if (o_done_i) begin
        done_cnt_d = done_cnt_q + 1'b1;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they line up exactly with the state register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= S_IDLE;
      k_cnt_q    <= '0;
      row_cnt_q  <= '0;
      done_cnt_q <= '0;
      op_q       <= OP_NOP;
      acc_q      <= 1'b0;
      kt_q       <= '0;
      rows_q     <= '0;
      w_read_q   <= 1'b0;
      if_read_q  <= 1'b0;
      clr_q      <= 1'b0;
      switch_q   <= 1'b0;
      first_q    <= 1'b0;
      last_q     <= 1'b0;
      busy_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_cnt_q    <= k_cnt_d;
      row_cnt_q  <= row_cnt_d;
      done_cnt_q <= done_cnt_d;
      op_q       <= op_d;
      acc_q      <= acc_d;
      kt_q       <= kt_d;
      rows_q     <= rows_d;
      w_read_q   <= (state_d == S_LOAD_W);
      if_read_q  <= (state_d == S_STREAM);
      clr_q      <= (state_d == S_CLR);
      switch_q   <= (state_d == S_SWITCH);
      first_q    <= (state_d == S_STREAM) && (k_cnt_d == '0) && !acc_d;
      last_q     <= (state_d == S_STREAM) && (k_cnt_d == kt_d);
      busy_q     <= (state_d != S_IDLE);
      err_q      <= (state_d == S_FETCH) && op_d[1];
    end
  end

  assign instr_ready_o = !fifo_full;
  assign w_read_o      = w_read_q;
  assign if_read_o     = if_read_q;
  assign clr_w_o       = clr_q;
  assign clr_if_o      = clr_q;
  assign switch_o      = switch_q;
  assign first_o       = first_q;
  assign last_o        = last_q;
  assign busy_o        = busy_q;
  assign err_o         = err_q;
  assign done_cnt_o    = done_cnt_q;
  // Completion must coincide with the o_done cycle, so it is gated directly.
  assign instr_done_o  = (state_q == S_DRAIN) && o_done_i;

endmodule
